timer_alarm_sched: RTL
======================

TIMER_ALARM_SCHED -- requirements
Module: timer_alarm_sched

Interface
REQ-001 Parameter CNT_W, default 32, SHALL set the width of delay and count values.
REQ-002 clk  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-004 i_enable  in  1  SHALL enable the scheduler (1 = run, 0 = hold idle).
REQ-005 i_useclk  in  1  SHALL select the count strobe (1 = rising edge of i_tick, 0 = every clk).
REQ-006 i_tick  in  1  SHALL be the prescaled tick input from the clock divider.
REQ-007 i_req  in  4  SHALL carry level requests, one per requester; held until o_grant.
REQ-008 i_delay0..i_delay3  in  CNT_W each  SHALL give each requester's timeout in strobes.
REQ-009 i_cancel  in  4  SHALL carry per-requester abort requests.
REQ-010 o_grant  out  4  SHALL carry a one-hot 1-cycle pulse marking the requester just loaded.
REQ-011 o_done  out  4  SHALL carry a one-hot 1-cycle pulse marking timeout expiry.
REQ-012 o_busy  out  1  SHALL be 1 whenever state is not IDLE.
REQ-013 o_active_id  out  2  SHALL give the index of the requester owning the counter.
REQ-014 o_count  out  CNT_W  SHALL give the remaining strobes of the active timeout.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 Strobe: with i_useclk=1, a registered copy of i_tick SHALL detect 0->1, giving one strobe per rising edge; with i_useclk=0, every clk SHALL be a strobe.
REQ-017 IDLE, i_enable=1, |i_req=1: the block SHALL pick the first set bit searching ptr, ptr+1, ... mod 4.
REQ-018 On that edge the block SHALL load o_count from the winner's i_delay, set o_active_id, pulse o_grant[winner] for the next cycle and enter RUN.
REQ-019 i_delay=0 at grant SHALL enter DONE directly, so o_done is the cycle after the o_grant pulse.
REQ-020 RUN: each strobe SHALL decrement o_count; a strobe with o_count==1 SHALL set o_count to 0 and enter DONE.
REQ-021 DONE SHALL last exactly one cycle, with o_done[o_active_id]=1, ptr<=o_active_id+1 mod 4, then IDLE.
REQ-022 In RUN, i_cancel[o_active_id]=1 SHALL force IDLE, o_count<=0 and ptr<=o_active_id+1, with no o_done.
REQ-023 i_cancel bits for non-active requesters SHALL be ignored.
REQ-024 Expiry and cancel on the same edge: expiry SHALL win and o_done SHALL pulse.
REQ-025 Requests arriving during RUN/DONE SHALL wait; no grant SHALL occur in DONE; arbitration SHALL resume in IDLE.
REQ-026 i_enable=0 SHALL force, synchronously, IDLE, o_count=0, o_grant=0 and o_done=0, and ptr SHALL be kept; it SHALL override all other events.
REQ-027 The decrement SHALL be modulo 2^CNT_W unsigned; RUN SHALL never be entered with o_count=0.

Reset
REQ-028 rst=0 SHALL immediately set: state IDLE, ptr 0, tick register 0, o_grant 0, o_done 0, o_busy 0, o_active_id 0, o_count 0.
REQ-029 Reset asserted mid-RUN SHALL discard the timeout with no o_done; release SHALL take effect on the first clk edge with rst=1.

Configuration
REQ-030 Macro TIMER_ALARM_SCHED_CANCEL_EN defined: i_cancel SHALL behave per REQ-022..024.
REQ-031 Macro TIMER_ALARM_SCHED_CANCEL_EN undefined: i_cancel SHALL remain a port but be ignored; every granted timeout SHALL end in o_done.

Verification
REQ-032 i_useclk=0, i_req=0001, i_delay0=3 -> o_grant=0001 pulse; o_count 3,2,1,0; o_done=0001 one cycle later; o_busy high 5 cycles.
REQ-033 i_req=1111 held, all delays=2 -> grants in order 0,1,2,3,0; each o_done precedes the next o_grant.
REQ-034 i_useclk=1, i_tick period 4 clk, i_delay1=2 -> o_done[1] one cycle after the 2nd tick rising edge post-grant; idle clks change nothing.
REQ-035 CANCEL_EN, active id 2, i_cancel=0100 at o_count=5 -> IDLE next edge, no o_done, next grant from id 3; same cancel on the o_count==1 strobe -> o_done=0100.
REQ-036 i_delay0=0 -> o_done=0001 the cycle after o_grant=0001; i_enable=0 mid-RUN -> o_count=0, o_busy=0, no o_done.
REQ-037 rst pulsed low mid-RUN with o_count=7 -> all outputs 0 immediately without clk; after release, arbitration restarts from id 0.

Source files
------------

// File: rtl/timer_alarm_sched.sv
// timer_alarm_sched: four-requester timeout scheduler sharing a single down-counter.
// Requesters are served round-robin. The counter decrements on every clk or on
// each rising edge of i_tick, depending on i_useclk.
// Optional feature: define TIMER_ALARM_SCHED_CANCEL_EN to let i_cancel abort the
// active timeout. When it is undefined, i_cancel is accepted but ignored.
module timer_alarm_sched #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_useclk,
  input  logic             i_tick,
  input  logic [3:0]       i_req,
  input  logic [CNT_W-1:0] i_delay0,
  input  logic [CNT_W-1:0] i_delay1,
  input  logic [CNT_W-1:0] i_delay2,
  input  logic [CNT_W-1:0] i_delay3,
  input  logic [3:0]       i_cancel,
  output logic [3:0]       o_grant,
  output logic [3:0]       o_done,
  output logic             o_busy,
  output logic [1:0]       o_active_id,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg;
  logic [1:0]       ptr_reg;
  logic [1:0]       active_reg;
  logic             tick_reg;
  logic [3:0]       grant_reg;
  logic [3:0]       done_reg;
  logic [CNT_W-1:0] count_reg;

  logic [CNT_W-1:0] delay_arr [4];
  logic [3:0]       req_rot;
  logic [1:0]       win_off;
  logic [1:0]       win_id;
  logic             strobe;
  logic             cancel_hit;

  assign delay_arr[0] = i_delay0;
  assign delay_arr[1] = i_delay1;
  assign delay_arr[2] = i_delay2;
  assign delay_arr[3] = i_delay3;

  // Rotate the request vector so that bit 0 is the requester at the round-robin pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = i_req[ptr_reg + 2'(gi)];
    end
  endgenerate

  // The first set bit of the rotated vector, mapped back to an absolute requester id.
  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) win_off = 2'(k);
    end
    win_id = ptr_reg + win_off;
  end

  // Count strobe: either every clk, or a single-cycle pulse on each rising edge of i_tick.
  assign strobe = i_useclk ? (i_tick & ~tick_reg) : 1'b1;

`ifdef TIMER_ALARM_SCHED_CANCEL_EN
  assign cancel_hit = i_cancel[active_reg];
`else
  logic unused_cancel;
  assign unused_cancel = ^i_cancel;
  assign cancel_hit    = 1'b0;
`endif

  // Scheduler FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= 2'd0;
      active_reg <= 2'd0;
      tick_reg   <= 1'b0;
      grant_reg  <= 4'd0;
      done_reg   <= 4'd0;
      count_reg  <= '0;
    end else begin
      tick_reg  <= i_tick;
      grant_reg <= 4'd0;
      done_reg  <= 4'd0;
      if (!i_enable) begin
        // Disable overrides every other event. The pointer is kept for fairness.
        state_reg <= IDLE;
        count_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (|i_req) begin
              count_reg  <= delay_arr[win_id];
              active_reg <= win_id;
              grant_reg  <= 4'b0001 << win_id;
              // A zero delay goes straight to DONE, so RUN never holds a zero count.
              state_reg  <= (delay_arr[win_id] == '0) ? DONE : RUN;
            end
          end
          RUN: begin
            // Expiry is tested first, so it wins over a cancel arriving on the same edge.
            if (strobe && count_reg == CNT_W'(1)) begin
              count_reg <= '0;
              state_reg <= DONE;
            end else if (cancel_hit) begin
              count_reg <= '0;
              ptr_reg   <= active_reg + 2'd1;
              state_reg <= IDLE;
            end else if (strobe) begin
              count_reg <= count_reg - CNT_W'(1);
            end
          end
          DONE: begin
            done_reg  <= 4'b0001 << active_reg;
            ptr_reg   <= active_reg + 2'd1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign o_grant     = grant_reg;
  assign o_done      = done_reg;
  assign o_active_id = active_reg;
  assign o_count     = count_reg;
  // Busy covers the completion pulse, so a requester sees busy until its o_done.
  assign o_busy      = (state_reg != IDLE) | (|done_reg);

endmodule
